// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared constants and FSM state for the systolic array feeder
package sa_pkg;

  localparam int N  = 4;
  localparam int K  = 16;
  localparam int DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } sa_state_t;

  // Cycles from T0 until the last PE on the anti-diagonal has folded in its final beat.
  function automatic int done_lat(input int n, input int k);
    return 2 * (n - 1) + k + 1;
  endfunction

  localparam int DONE_LAT = done_lat(N, K);

endpackage

// File: rtl/skew_line.sv
// rtl/skew_line.sv - DW-wide delay chain of DEPTH stages with synchronous flush
module skew_line #(
  parameter int DW    = 16,
  parameter int DEPTH = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      // Lane 0 has no skew; the clock, reset and flush are not needed here.
      logic unused_ok;
      assign unused_ok = ^{clk, rst_n, flush};
      assign q = d;
    end else begin : g_chain
      logic [DW-1:0] stage [DEPTH];

      // Shift the element one stage per cycle; flush empties the whole line at once.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage <= '{default: '0};
        end else if (flush) begin
          stage <= '{default: '0};
        end else begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sa_feeder.sv
// rtl/sa_feeder.sv - buffers one K-beat tile and streams it skewed into an N x N systolic array
module sa_feeder #(
  parameter int N  = 4,
  parameter int K  = 16,
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [N*DW-1:0]   s_map,
  input  logic [N*DW-1:0]   s_weight,
  output logic [N*DW-1:0]   o_map,
  output logic [N*DW-1:0]   o_weight,
  output logic [2*N-2:0]    o_clear,
  output logic              o_busy,
  output logic              o_done
);

  import sa_pkg::sa_state_t;
  import sa_pkg::ST_IDLE;
  import sa_pkg::ST_LOAD;
  import sa_pkg::ST_STREAM;
  import sa_pkg::ST_DRAIN;

  localparam int CW   = $clog2(K);
  localparam int DONE = sa_pkg::done_lat(N, K);
  localparam int TW   = $clog2(DONE + 1);
  localparam int LW   = N * DW;
  localparam int CLRW = 2 * N - 1;

  sa_state_t     state;
  logic [CW-1:0] beat_cnt;
  logic [TW-1:0] cyc_cnt;
  logic [LW-1:0] tile_map [K];
  logic [LW-1:0] tile_wgt [K];
  logic [LW-1:0] src_map;
  logic [LW-1:0] src_wgt;
  logic          accept;

  // Abort always wins over an offered beat.
  assign accept = s_valid && s_ready && !i_abort;

  // Tile buffer: written in arrival order, contents hold through any gaps.
  always_ff @(posedge clk) begin
    if (accept) begin
      tile_map[beat_cnt] <= s_map;
      tile_wgt[beat_cnt] <= s_weight;
    end
  end

  // Control FSM: cyc_cnt is 0 in T0, so the done pulse lands in cycle T0+DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      cyc_cnt  <= '0;
      s_ready  <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_clear  <= '0;
    end else if (i_abort) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      cyc_cnt  <= '0;
      s_ready  <= 1'b1;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_clear  <= '0;
    end else begin
      o_done  <= 1'b0;
      o_clear <= o_clear << 1;
      case (state)
        ST_IDLE, ST_LOAD: begin
          s_ready <= 1'b1;
          if (accept) begin
            if (beat_cnt == CW'(K - 1)) begin
              state    <= ST_STREAM;
              beat_cnt <= '0;
              cyc_cnt  <= '0;
              s_ready  <= 1'b0;
              o_busy   <= 1'b1;
              o_clear  <= CLRW'(1);
            end else begin
              state    <= ST_LOAD;
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        ST_STREAM: begin
          cyc_cnt <= cyc_cnt + TW'(1);
          if (cyc_cnt == TW'(DONE - 1)) o_done <= 1'b1;
          if (cyc_cnt == TW'(K)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          cyc_cnt <= cyc_cnt + TW'(1);
          if (cyc_cnt == TW'(DONE - 1)) o_done <= 1'b1;
          if (cyc_cnt == TW'(DONE)) begin
            state   <= ST_IDLE;
            cyc_cnt <= '0;
            s_ready <= 1'b1;
            o_busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Unskewed source: beat b appears in T0+1+b, zero outside the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_map <= '0;
      src_wgt <= '0;
    end else if (i_abort) begin
      src_map <= '0;
      src_wgt <= '0;
    end else if (state == ST_STREAM && cyc_cnt < TW'(K)) begin
      src_map <= tile_map[cyc_cnt[CW-1:0]];
      src_wgt <= tile_wgt[cyc_cnt[CW-1:0]];
    end else begin
      src_map <= '0;
      src_wgt <= '0;
    end
  end

  // Lane k is delayed k cycles so each anti-diagonal of PEs sees aligned operands.
  generate
    for (genvar k = 0; k < N; k++) begin : g_lane
      skew_line #(.DW(DW), .DEPTH(k)) u_map_skew (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (i_abort),
        .d     (src_map[k*DW +: DW]),
        .q     (o_map[k*DW +: DW])
      );
      skew_line #(.DW(DW), .DEPTH(k)) u_wgt_skew (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (i_abort),
        .d     (src_wgt[k*DW +: DW]),
        .q     (o_weight[k*DW +: DW])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sa_feeder.sv
// tb/tb_sa_feeder.sv - directed self-checking bench for sa_feeder with a 4x4 PE model
module tb_sa_feeder;

  localparam int N      = 4;
  localparam int K      = 16;
  localparam int DW     = 16;
  localparam int LW     = N * DW;
  localparam int CLRW   = 2 * N - 1;
  localparam int DONE_T = 23;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_abort = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [LW-1:0]   s_map = '0;
  logic [LW-1:0]   s_weight = '0;
  logic [LW-1:0]   o_map;
  logic [LW-1:0]   o_weight;
  logic [CLRW-1:0] o_clear;
  logic            o_busy;
  logic            o_done;

  sa_feeder #(.N(N), .K(K), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_abort  (i_abort),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_map    (s_map),
    .s_weight (s_weight),
    .o_map    (o_map),
    .o_weight (o_weight),
    .o_clear  (o_clear),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int t0       = 0;

  logic [DW-1:0] tm [K][N];
  logic [DW-1:0] tw [K][N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // 4x4 output-stationary PE array: map flows east, weight flows south, Q8.8 MAC.
  logic signed [DW-1:0] pe_a [N][N];
  logic signed [DW-1:0] pe_b [N][N];
  logic        [DW-1:0] acc  [N][N];

  always @(posedge clk or negedge rst_n) begin : pe_model
    logic signed [DW-1:0]   a_in;
    logic signed [DW-1:0]   b_in;
    logic signed [2*DW-1:0] prod;
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          pe_a[i][j] <= '0;
          pe_b[i][j] <= '0;
          acc[i][j]  <= '0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_in = (j == 0) ? o_map[i*DW +: DW] : pe_a[i][j-1];
          b_in = (i == 0) ? o_weight[j*DW +: DW] : pe_b[i-1][j];
          prod = a_in * b_in;
          pe_a[i][j] <= a_in;
          pe_b[i][j] <= b_in;
          if (o_clear[i+j]) acc[i][j] <= '0;
          else              acc[i][j] <= acc[i][j] + prod[DW+7:8];
        end
    end
  end

  task automatic set_tile(input int kind);
    for (int b = 0; b < K; b++)
      for (int k = 0; k < N; k++) begin
        case (kind)
          0:       begin tm[b][k] = 16'h0100; tw[b][k] = 16'h0100; end
          1:       begin tm[b][k] = 16'((k << 8) | (b + 1)); tw[b][k] = 16'(16'hF000 | (k << 8) | b); end
          default: begin tm[b][k] = 16'hFF00; tw[b][k] = 16'h0200; end
        endcase
      end
  endtask

  // Starts and ends on a falling edge; for a full tile t0 is the cycle after the last accept.
  task automatic load_tile(input int gap, input int nbeats, input logic hold);
    int b = 0;
    int guard = 0;
    int start;
    logic took;
    start = cyc;
    while (b < nbeats && guard < 400) begin
      if (guard % (gap + 1) == 0) begin
        s_valid = 1'b1;
        for (int k = 0; k < N; k++) begin
          s_map[k*DW +: DW]    = tm[b][k];
          s_weight[k*DW +: DW] = tw[b][k];
        end
      end else begin
        s_valid  = 1'b0;
        s_map    = {N{16'hDEAD}};
        s_weight = {N{16'hBEEF}};
      end
      took = s_valid && s_ready;
      if (took) begin
        b++;
        if (b == K) t0 = cyc + 1;
      end
      @(negedge clk);
      guard++;
      if (took) chk($sformatf("busy_load beat %0d", b), o_busy, (b == K));
    end
    chk("load_count", b, nbeats);
    if (gap == 0 && nbeats == K) chk("load_cycles", t0 - start, K);
    if (hold) begin
      s_valid  = 1'b1;
      s_map    = {N{16'h7777}};
      s_weight = {N{16'h7777}};
    end else begin
      s_valid = 1'b0;
    end
  endtask

  // Walks cycles T0..T0+DONE_T against the closed-form lane windows.
  task automatic check_tile(input logic use_pe, input logic [DW-1:0] pe_exp);
    logic [LW-1:0]   exp_map;
    logic [LW-1:0]   exp_wgt;
    logic [CLRW-1:0] exp_clr;
    int rel;
    for (int t = t0; t <= t0 + DONE_T; t++) begin
      exp_map = '0;
      exp_wgt = '0;
      exp_clr = '0;
      for (int k = 0; k < N; k++) begin
        rel = t - t0 - 1 - k;
        if (rel >= 0 && rel < K) begin
          exp_map[k*DW +: DW] = tm[rel][k];
          exp_wgt[k*DW +: DW] = tw[rel][k];
        end
      end
      for (int d = 0; d < CLRW; d++) exp_clr[d] = (t == t0 + d);
      chk($sformatf("o_map T0+%0d", t - t0), o_map, exp_map);
      chk($sformatf("o_weight T0+%0d", t - t0), o_weight, exp_wgt);
      chk($sformatf("o_clear T0+%0d", t - t0), o_clear, exp_clr);
      chk($sformatf("o_done T0+%0d", t - t0), o_done, (t == t0 + DONE_T));
      chk($sformatf("s_ready T0+%0d", t - t0), s_ready, 1'b0);
      if (t < t0 + DONE_T) chk($sformatf("o_busy T0+%0d", t - t0), o_busy, 1'b1);
      if (t == t0 + DONE_T && use_pe)
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            chk($sformatf("pe_result %0d,%0d", i, j), acc[i][j], pe_exp);
      if (t < t0 + DONE_T) @(negedge clk);
    end
  endtask

  task automatic post_done();
    @(negedge clk);
    chk("o_done after done", o_done, 1'b0);
    chk("s_ready after done", s_ready, 1'b1);
    chk("o_busy after done", o_busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen_done;
    logic seen_data;

    repeat (3) @(negedge clk);
    chk("rst s_ready", s_ready, 1'b0);
    chk("rst o_busy", o_busy, 1'b0);
    chk("rst o_done", o_done, 1'b0);
    chk("rst o_map", o_map, '0);
    chk("rst o_weight", o_weight, '0);
    chk("rst o_clear", o_clear, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready after release", s_ready, 1'b1);

    // Uniform dense tile, then the same tile loaded sparsely.
    set_tile(0);
    load_tile(0, K, 1'b0);
    check_tile(1'b1, 16'h1000);
    post_done();
    load_tile(2, K, 1'b0);
    check_tile(1'b1, 16'h1000);
    post_done();

    // Patterned tile with s_valid held through streaming, then a back-to-back tile.
    set_tile(1);
    load_tile(0, K, 1'b1);
    check_tile(1'b0, '0);
    post_done();
    set_tile(0);
    load_tile(0, K, 1'b0);
    check_tile(1'b1, 16'h1000);
    post_done();

    // Abort at T0+5.
    set_tile(1);
    load_tile(0, K, 1'b0);
    repeat (5) @(negedge clk);
    chk("abort pre o_clear", o_clear, CLRW'(1 << 5));
    chk("abort pre lane0", o_map[DW-1:0], tm[4][0]);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("abort o_map", o_map, '0);
    chk("abort o_weight", o_weight, '0);
    chk("abort o_clear", o_clear, '0);
    chk("abort o_busy", o_busy, 1'b0);
    chk("abort s_ready", s_ready, 1'b1);
    seen_done = 1'b0;
    seen_data = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen_done = seen_done | o_done;
      seen_data = seen_data | (|o_map) | (|o_weight) | (|o_clear);
    end
    chk("abort no o_done", seen_done, 1'b0);
    chk("abort lanes flushed", seen_data, 1'b0);

    // Abort and valid together in LOAD: beat dropped, counter back to 0.
    set_tile(0);
    load_tile(0, 3, 1'b0);
    s_valid = 1'b1;
    i_abort = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    i_abort = 1'b0;
    chk("abort+valid s_ready", s_ready, 1'b1);
    chk("abort+valid o_busy", o_busy, 1'b0);
    load_tile(0, K, 1'b0);
    check_tile(1'b1, 16'h1000);
    post_done();

    // Asynchronous reset after 7 loaded beats, then a negative tile.
    set_tile(1);
    load_tile(0, 7, 1'b0);
    chk("pre-reset s_ready", s_ready, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async rst s_ready", s_ready, 1'b0);
    chk("async rst o_busy", o_busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready after mid reset", s_ready, 1'b1);
    set_tile(2);
    load_tile(0, K, 1'b0);
    check_tile(1'b1, 16'hE000);
    post_done();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sa_feeder.md
SA_FEEDER -- requirements
Module: sa_feeder

Interface
REQ-001 SHALL have parameter N, default 4, meaning lanes per array edge (array is N x N PEs).
REQ-002 SHALL have parameter K, default 16, meaning beats per tile; fixed by the PE 16-cycle accumulate window.
REQ-003 SHALL have parameter DW, default 16, meaning signed Q8.8 element width.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_abort  input  1  synchronous tile abort.
REQ-007 SHALL have port s_valid  input  1  upstream beat valid.
REQ-008 SHALL have port s_ready  output  1  feeder accepts beat.
REQ-009 SHALL have port s_map  input  N*DW  one map element per row lane, lane k at [k*DW +: DW].
REQ-010 SHALL have port s_weight  input  N*DW  one weight element per column lane, same packing.
REQ-011 SHALL have port o_map  output  N*DW  skewed map to west-edge PEs.
REQ-012 SHALL have port o_weight  output  N*DW  skewed weight to north-edge PEs.
REQ-013 SHALL have port o_clear  output  2N-1  clear pulses; bit d drives every PE(i,j) with i+j=d.
REQ-014 SHALL have port o_busy  output  1  high in STREAM and DRAIN.
REQ-015 SHALL have port o_done  output  1  one-cycle pulse when all PE results are final.

Function
REQ-016 SHALL implement FSM IDLE, LOAD, STREAM, DRAIN.
REQ-017 s_ready SHALL be 1 in IDLE and LOAD, 0 in STREAM and DRAIN; a beat is accepted when s_valid and s_ready are both 1.
REQ-018 Accepted beats SHALL be written in order to a K-entry tile buffer; 4-bit beat counter; IDLE->LOAD on first accepted beat.
REQ-019 Gaps in s_valid during LOAD SHALL be tolerated with no limit; buffer contents hold.
REQ-020 Acceptance of beat K-1 in cycle L SHALL cause LOAD->STREAM; T0 = L+1.
REQ-021 o_clear[d] SHALL pulse high for exactly cycle T0+d, d = 0..2N-2.
REQ-022 Lane k of o_map and o_weight SHALL carry buffer beat b in cycle T0+1+b+k, b = 0..K-1, with no bubbles.
REQ-023 Every lane SHALL drive 0 in every cycle outside its K-beat window.
REQ-024 Data SHALL pass bit-exact: no arithmetic, no saturation, signedness preserved.
REQ-025 STREAM->DRAIN SHALL occur after lane-0 beat K-1; DRAIN SHALL last until T0+2(N-1)+K.
REQ-026 o_done SHALL be high only in cycle T0+2(N-1)+K+1 (T0+23 at defaults); the FSM SHALL be IDLE and s_ready 1 from the next cycle.
REQ-027 i_abort in any state SHALL return to IDLE next cycle: counter 0, o_clear/o_map/o_weight 0, skew lines flushed, no o_done.
REQ-028 If s_valid and i_abort are both high in one cycle, abort SHALL win; the beat is not accepted.
REQ-029 A beat SHALL be acceptable in the cycle after o_done; back-to-back tiles SHALL have no extra idle cycles.

Reset
REQ-030 While rst_n is low, all outputs SHALL be 0 except s_ready, which SHALL be 0 during reset and 1 from the first clock after release.
REQ-031 Reset SHALL put the FSM in IDLE, the beat counter at 0 and skew lines at 0; buffer contents are don't-care.
REQ-032 Reset asserted mid-tile SHALL discard the tile immediately (asynchronous).

Structure
REQ-033 A shared package sa_pkg SHALL hold N, K, DW, the FSM state enum and DONE_LAT = 2(N-1)+K+1.
REQ-034 Sub-module skew_line SHALL be a parameterised DW-wide delay chain (depth k, k=0 meaning a wire) with synchronous flush; one instance per o_map and o_weight lane.

Verification
REQ-035 Uniform tile (all map and weight 0x0100) SHALL give o_map[lane0]=0x0100 in T0+1..T0+16, lane3 in T0+4..T0+19, 0 elsewhere; a 4x4 PE model SHALL read o_result 0x1000 everywhere after o_done at T0+23.
REQ-036 Sparse load (s_valid every third cycle) SHALL still produce a gapless 16-beat window and correct results.
REQ-037 s_valid held high through STREAM SHALL give s_ready=0 and no buffer change; the next tile SHALL be accepted the cycle after o_done.
REQ-038 i_abort at T0+5 SHALL give all lanes 0 and o_busy 0 at T0+6, with no o_done ever asserted.
REQ-039 rst_n pulse after 7 loaded beats, then 16 beats of map=-0x0100 and weight=0x0200, SHALL give PE o_result 0xE000 (-32.0) everywhere.
REQ-040 Simultaneous i_abort and s_valid in LOAD SHALL leave the counter at 0.
